// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the RISC-V front end: registered fetch address,
// combinational PC+4 link value, and a one-cycle misaligned-redirect flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_value,
    output logic        redirect_misaligned
);

    logic [31:0] pc_q;
    logic        misaligned_q;

    // Carry out of bit 31 is dropped, so 0xFFFF_FFFC wraps to 0.
    assign pc_plus_4_value = pc_q + 32'd4;

    // Priority: reset, then redirect (a flush must never be lost to a stall),
    // then stall, then sequential advance. Every path assigns both registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= {redirect_target[31:2], 2'b00};
            misaligned_q <= (redirect_target[1:0] != 2'b00);
        end else if (stall) begin
            pc_q         <= pc_q;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_plus_4_value;
            misaligned_q <= 1'b0;
        end
    end

    assign pc_out              = pc_q;
    assign redirect_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_value;
    logic        redirect_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_pc;
    logic        model_mis;
    bit          model_valid = 1'b0;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .pc_out              (pc_out),
        .pc_plus_4_value     (pc_plus_4_value),
        .redirect_misaligned (redirect_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the PC must become after each edge.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            model_pc    = 32'h0000_0000;
            model_mis   = 1'b0;
            model_valid = 1'b1;
        end else if (redirect_valid) begin
            model_pc  = redirect_target - (redirect_target % 4);
            model_mis = (redirect_target % 4) != 0;
        end else if (stall) begin
            model_mis = 1'b0;
        end else begin
            model_pc  = model_pc + 4;
            model_mis = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_pc_out", pc_out, model_pc);
            check("model_pc_plus_4", pc_plus_4_value, model_pc + 32'd4);
            check("model_misaligned", {31'd0, redirect_misaligned}, {31'd0, model_mis});
        end
    end

    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
        reset           = rst;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string name, input logic [31:0] pc, input logic mis);
        check({name, "_pc"}, pc_out, pc);
        check({name, "_p4"}, pc_plus_4_value, pc + 32'd4);
        check({name, "_mis"}, {31'd0, redirect_misaligned}, {31'd0, mis});
    endtask

    initial begin
        reset           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset then run
        step(1'b0, 1'b0, 1'b0, 32'h0);
        expect_pc("reset", 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("run1", 32'h4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("run2", 32'h8, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("run3", 32'hC, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("run4", 32'h10, 1'b0);

        // Reset mid-run; redirect and stall must lose to it
        step(1'b0, 1'b1, 1'b1, 32'h5000);
        expect_pc("midreset", 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("postreset", 32'h4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("pre_stall", 32'h8, 1'b0);

        // Stall for three edges
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            expect_pc("stall", 32'h8, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("stall_release", 32'hC, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("reach_20", 32'h20, 1'b0);

        // Redirect beats stall
        step(1'b1, 1'b1, 1'b1, 32'h1000);
        expect_pc("redir_vs_stall", 32'h1000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("after_redir", 32'h1004, 1'b0);

        // Misaligned redirect
        step(1'b1, 1'b0, 1'b1, 32'h2002);
        expect_pc("misaligned", 32'h2000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("mis_clear", 32'h2004, 1'b0);

        // Wrap-around
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_p4", pc_plus_4_value, 32'h0000_0000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_pc("wrapped", 32'h0, 1'b0);

        // Randomized traffic checked by the model on every negedge
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_st;
            logic        r_rv;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            r_st  = ($urandom_range(0, 99) < 30);
            r_rv  = ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 3))
                0:       r_tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
                1:       r_tgt = $urandom() & 32'h0000_00FF;
                default: r_tgt = $urandom();
            endcase
            step(r_rst, r_st, r_rv, r_tgt);
        end

        step(1'b1, 1'b0, 1'b0, 32'h0);
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
